// File: rtl/hash_stream_sequencer.sv
// Front end for the DES-based hash core. It accepts a multi-byte ready/valid
// message stream of unknown length and counts the bytes. It serialises the
// stream one byte per transfer to the core and appends a trailer: a marker
// byte followed by the big-endian message length. Finally it captures the
// core's digest and holds it for the consumer.
// Ports:
//   clk, rst                         clock, async active-high reset
//   s_valid/s_ready/s_data/s_keep/s_last   input beat stream (lane 0 first)
//   c_valid/c_ready/c_byte/c_first/c_last  byte stream to the core
//   c_digest/c_digest_valid          digest returned by the core
//   digest/digest_valid              captured digest for the consumer
//   msg_len/len_ovf                  byte count of the message, saturation flag
//   busy                             sequencer not idle
module hash_stream_sequencer #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned LEN_W    = 64,
  parameter int unsigned DIGEST_W = 32,
  parameter logic [7:0]  PAD_MARK = 8'h80
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [8*LANES-1:0]           s_data,
  input  logic [$clog2(LANES+1)-1:0]   s_keep,
  input  logic                         s_last,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic [7:0]                   c_byte,
  output logic                         c_first,
  output logic                         c_last,
  input  logic [DIGEST_W-1:0]          c_digest,
  input  logic                         c_digest_valid,
  output logic [DIGEST_W-1:0]          digest,
  output logic                         digest_valid,
  output logic [LEN_W-1:0]             msg_len,
  output logic                         len_ovf,
  output logic                         busy
);

  localparam int unsigned KEEP_W = $clog2(LANES + 1);
  localparam int unsigned NB     = LEN_W / 8;
  localparam int unsigned LIDX_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_DATA        = 3'd1;
  localparam logic [2:0] ST_PAD_MARK    = 3'd2;
  localparam logic [2:0] ST_PAD_LEN     = 3'd3;
  localparam logic [2:0] ST_WAIT_DIGEST = 3'd4;

  logic [2:0]          state, state_n;
  logic [8*LANES-1:0]  beat_data, beat_data_n;
  logic [KEEP_W-1:0]   beat_keep, beat_keep_n;
  logic                beat_last, beat_last_n;
  logic [KEEP_W-1:0]   byte_idx, byte_idx_n;
  logic [LIDX_W-1:0]   len_idx, len_idx_n;
  logic                in_msg, in_msg_n;
  logic                c_valid_n, c_first_n, c_last_n;
  logic [7:0]          c_byte_n;
  logic [DIGEST_W-1:0] digest_n;
  logic                digest_valid_n, len_ovf_n, busy_n;
  logic [LEN_W-1:0]    msg_len_n;

  logic                hs, last_lane, do_load, first_beat;
  logic [KEEP_W-1:0]   keep_c;

  // Byte idx of the held beat, lane 0 in the low bits.
  function automatic logic [7:0] lane_byte(input logic [8*LANES-1:0] d,
                                           input logic [KEEP_W-1:0] idx);
    int sh;
    sh = 8 * int'(idx);
    return 8'(d >> sh);
  endfunction

  // Length byte idx, most significant byte first.
  function automatic logic [7:0] len_byte(input logic [LEN_W-1:0] len,
                                          input logic [LIDX_W-1:0] idx);
    int sh;
    sh = 8 * (int'(NB) - 1 - int'(idx));
    return 8'(len >> sh);
  endfunction

  assign hs        = c_valid && c_ready;
  assign last_lane = (byte_idx == beat_keep - KEEP_W'(1));
  assign keep_c    = (s_keep > KEEP_W'(LANES)) ? KEEP_W'(LANES) : s_keep;
  // Beats with no bytes and no end-of-message carry nothing and are dropped.
  assign first_beat = !in_msg && ((keep_c != '0) || s_last);

  // Ready in IDLE, or while the final byte of a non-final beat leaves, so
  // consecutive beats stream without a bubble.
  assign s_ready = !rst && ((state == ST_IDLE) ||
                            ((state == ST_DATA) && hs && last_lane && !beat_last));

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      beat_data    <= '0;
      beat_keep    <= '0;
      beat_last    <= 1'b0;
      byte_idx     <= '0;
      len_idx      <= '0;
      in_msg       <= 1'b0;
      c_valid      <= 1'b0;
      c_byte       <= '0;
      c_first      <= 1'b0;
      c_last       <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      msg_len      <= '0;
      len_ovf      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      beat_data    <= beat_data_n;
      beat_keep    <= beat_keep_n;
      beat_last    <= beat_last_n;
      byte_idx     <= byte_idx_n;
      len_idx      <= len_idx_n;
      in_msg       <= in_msg_n;
      c_valid      <= c_valid_n;
      c_byte       <= c_byte_n;
      c_first      <= c_first_n;
      c_last       <= c_last_n;
      digest       <= digest_n;
      digest_valid <= digest_valid_n;
      msg_len      <= msg_len_n;
      len_ovf      <= len_ovf_n;
      busy         <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n        = state;
    beat_data_n    = beat_data;
    beat_keep_n    = beat_keep;
    beat_last_n    = beat_last;
    byte_idx_n     = byte_idx;
    len_idx_n      = len_idx;
    in_msg_n       = in_msg;
    c_valid_n      = c_valid;
    c_byte_n       = c_byte;
    c_first_n      = c_first;
    c_last_n       = c_last;
    digest_n       = digest;
    digest_valid_n = digest_valid;
    msg_len_n      = msg_len;
    len_ovf_n      = len_ovf;
    do_load        = 1'b0;

    case (state)
      ST_IDLE: begin
        do_load = s_valid;
      end
      ST_DATA: begin
        if (hs) begin
          if (&msg_len) len_ovf_n = 1'b1;
          else          msg_len_n = msg_len + LEN_W'(1);
          c_first_n = 1'b0;
          if (last_lane) begin
            if (beat_last) begin
              state_n  = ST_PAD_MARK;
              c_byte_n = PAD_MARK;
            end else if (s_valid) begin
              do_load = 1'b1;
            end else begin
              state_n   = ST_IDLE;
              c_valid_n = 1'b0;
            end
          end else begin
            byte_idx_n = byte_idx + KEEP_W'(1);
            c_byte_n   = lane_byte(beat_data, byte_idx + KEEP_W'(1));
          end
        end
      end
      ST_PAD_MARK: begin
        if (hs) begin
          state_n   = ST_PAD_LEN;
          len_idx_n = '0;
          c_byte_n  = len_byte(msg_len, '0);
          c_first_n = 1'b0;
          c_last_n  = (NB == 1);
        end
      end
      ST_PAD_LEN: begin
        if (hs) begin
          if (len_idx == LIDX_W'(NB - 1)) begin
            state_n   = ST_WAIT_DIGEST;
            c_valid_n = 1'b0;
            c_last_n  = 1'b0;
          end else begin
            len_idx_n = len_idx + LIDX_W'(1);
            c_byte_n  = len_byte(msg_len, len_idx + LIDX_W'(1));
            c_last_n  = ((len_idx + LIDX_W'(1)) == LIDX_W'(NB - 1));
          end
        end
      end
      ST_WAIT_DIGEST: begin
        if (c_digest_valid) begin
          digest_n       = c_digest;
          digest_valid_n = 1'b1;
          state_n        = ST_IDLE;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        c_valid_n = 1'b0;
      end
    endcase

    // Take a new beat and present its first byte (or the marker) next cycle.
    if (do_load) begin
      beat_data_n = s_data;
      beat_keep_n = keep_c;
      beat_last_n = s_last;
      byte_idx_n  = '0;
      c_last_n    = 1'b0;
      if (first_beat) begin
        digest_valid_n = 1'b0;
        msg_len_n      = '0;
        len_ovf_n      = 1'b0;
      end
      if ((keep_c != '0) || s_last) in_msg_n = !s_last;
      if (keep_c != '0) begin
        state_n   = ST_DATA;
        c_valid_n = 1'b1;
        c_byte_n  = s_data[7:0];
        c_first_n = first_beat;
      end else if (s_last) begin
        state_n   = ST_PAD_MARK;
        c_valid_n = 1'b1;
        c_byte_n  = PAD_MARK;
        c_first_n = first_beat;
      end else begin
        state_n   = ST_IDLE;
        c_valid_n = 1'b0;
        c_first_n = 1'b0;
      end
    end

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_hash_stream_sequencer.sv
// Directed bench for hash_stream_sequencer: table of messages with
// hand-computed trailer bytes, lengths and stub digests, plus a reset
// sequence and a stray-digest check.
module tb_hash_stream_sequencer;

  localparam int unsigned LANES    = 4;
  localparam int unsigned LEN_W    = 64;
  localparam int unsigned DIGEST_W = 32;
  localparam int unsigned KEEP_W   = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [8*LANES-1:0]  s_data = '0;
  logic [KEEP_W-1:0]   s_keep = '0;
  logic                s_last = 1'b0;
  logic                c_valid;
  logic                c_ready = 1'b0;
  logic [7:0]          c_byte;
  logic                c_first;
  logic                c_last;
  logic [DIGEST_W-1:0] c_digest = '0;
  logic                c_digest_valid = 1'b0;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic [LEN_W-1:0]    msg_len;
  logic                len_ovf;
  logic                busy;

  hash_stream_sequencer #(
    .LANES(LANES), .LEN_W(LEN_W), .DIGEST_W(DIGEST_W), .PAD_MARK(8'h80)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last),
    .c_valid(c_valid), .c_ready(c_ready), .c_byte(c_byte), .c_first(c_first),
    .c_last(c_last), .c_digest(c_digest), .c_digest_valid(c_digest_valid),
    .digest(digest), .digest_valid(digest_valid), .msg_len(msg_len),
    .len_ovf(len_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic [7:0]  base;
    bit          bp;
    logic [31:0] dig;
    int unsigned exp_count;
    logic [7:0]  exp_final;
    logic [7:0]  exp_pen;
    logic [63:0] exp_len;
  } vec_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  bit  bp_mode = 1'b0;

  logic [7:0] got_b[$];
  bit         got_f[$];
  bit         got_l[$];
  bit         got_sr[$];
  int         got_c[$];
  logic [7:0] prev_b[$];
  bit         last_done = 1'b0;
  int         hold_err = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_byte = '0;

  always @(posedge clk) cyc = cyc + 1;

  // Core stub ready: constant 1, or toggling every cycle for backpressure.
  always @(posedge clk) begin
    #1;
    c_ready = bp_mode ? ~c_ready : 1'b1;
  end

  // Core-side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!c_valid || c_byte != stall_byte)) hold_err = hold_err + 1;
      stall_prev = c_valid && !c_ready;
      stall_byte = c_byte;
      if (c_valid && c_ready) begin
        got_b.push_back(c_byte);
        got_f.push_back(c_first);
        got_l.push_back(c_last);
        got_sr.push_back(s_ready);
        got_c.push_back(cyc);
        if (c_last) last_done = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_b.delete(); got_f.delete(); got_l.delete(); got_sr.delete(); got_c.delete();
    last_done = 1'b0;
    hold_err  = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] exp_q[$];
    int nbeats, keep, mism, fsum, lsum, last;
    logic [31:0] d;
    bit ok;
    bp_mode = v.bp;
    clear_mon();
    for (int i = 0; i < int'(v.n); i++) exp_q.push_back(8'(v.base + 8'(i)));
    exp_q.push_back(8'h80);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(64'(v.n) >> (8 * (7 - k))));

    nbeats = (v.n == 0) ? 1 : (int'(v.n) + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      keep = int'(v.n) - 4 * b;
      if (keep > 4) keep = 4;
      if (keep < 0) keep = 0;
      d = 32'hAAAA_AAAA;
      for (int l = 0; l < keep; l++) d[8*l +: 8] = 8'(v.base + 8'(4 * b + l));
      s_data  = d;
      s_keep  = KEEP_W'(keep);
      s_last  = (b == nbeats - 1);
      s_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (s_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check({tag, "_beat_timeout"}, 0, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    for (int t = 0; t < 4000 && !last_done; t++) begin
      @(posedge clk); #2;
    end
    check({tag, "_trailer_seen"}, 64'(last_done), 1);
    check({tag, "_busy_wait"}, 64'(busy), 1);
    check({tag, "_cvalid_wait"}, 64'(c_valid), 0);

    repeat (2) @(posedge clk);
    #1;
    c_digest = v.dig;
    c_digest_valid = 1'b1;
    @(posedge clk); #1;
    c_digest_valid = 1'b0;
    c_digest = '0;
    #1;

    check({tag, "_count"}, 64'(got_b.size()), 64'(v.exp_count));
    mism = (got_b.size() != exp_q.size()) ? 1 : 0;
    if (mism == 0)
      for (int i = 0; i < got_b.size(); i++) if (got_b[i] !== exp_q[i]) mism = mism + 1;
    check({tag, "_seq"}, 64'(mism), 0);
    fsum = 0; lsum = 0;
    foreach (got_f[i]) fsum = fsum + int'(got_f[i]);
    foreach (got_l[i]) lsum = lsum + int'(got_l[i]);
    last = got_b.size() - 1;
    if (last >= 1) begin
      check({tag, "_final_byte"}, 64'(got_b[last]), 64'(v.exp_final));
      check({tag, "_pen_byte"}, 64'(got_b[last-1]), 64'(v.exp_pen));
      check({tag, "_first"}, {62'd0, got_f[0], fsum == 1}, 64'd3);
      check({tag, "_last"}, {62'd0, got_l[last], lsum == 1}, 64'd3);
      if (!v.bp) check({tag, "_gapless"}, 64'(got_c[last] - got_c[0]), 64'(last));
      if (!v.bp && v.n > 4) check({tag, "_sready_b3"}, 64'(got_sr[3]), 1);
    end else begin
      check({tag, "_nonempty"}, 64'(got_b.size()), 64'(v.exp_count));
    end
    check({tag, "_hold"}, 64'(hold_err), 0);
    check({tag, "_digest"}, 64'(digest), 64'(v.dig));
    check({tag, "_digest_valid"}, 64'(digest_valid), 1);
    check({tag, "_msg_len"}, 64'(msg_len), v.exp_len);
    check({tag, "_len_ovf"}, 64'(len_ovf), 0);
    check({tag, "_busy_done"}, 64'(busy), 0);
  endtask

  vec_t vt[7];
  bit   same;
  bit   ok2;

  initial begin
    //        n    base   bp    digest         cnt  final  pen    len
    vt[0] = '{0,   8'h00, 1'b0, 32'h956F7883,  9,   8'h00, 8'h00, 64'd0};
    vt[1] = '{1,   8'h41, 1'b0, 32'h2dd99066,  10,  8'h01, 8'h00, 64'd1};
    vt[2] = '{6,   8'h00, 1'b0, 32'h11111111,  15,  8'h06, 8'h00, 64'd6};
    vt[3] = '{6,   8'h00, 1'b1, 32'h22222222,  15,  8'h06, 8'h00, 64'd6};
    vt[4] = '{300, 8'h00, 1'b0, 32'h33333333,  309, 8'h2C, 8'h01, 64'd300};
    vt[5] = '{300, 8'h00, 1'b0, 32'h33333333,  309, 8'h2C, 8'h01, 64'd300};
    vt[6] = '{255, 8'h00, 1'b1, 32'h44444444,  264, 8'hFF, 8'h00, 64'd255};

    repeat (3) @(posedge clk);
    #1;
    check("rst_c_valid", 64'(c_valid), 0);
    check("rst_s_ready", 64'(s_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_digest_valid", 64'(digest_valid), 0);
    check("rst_outs", {c_byte, 8'(msg_len), 8'(digest), 5'd0, c_first, c_last, len_ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_s_ready", 64'(s_ready), 1);

    run_vec(vt[0], "empty");

    // A digest pulse outside WAIT_DIGEST must not disturb the held result.
    @(posedge clk); #1;
    c_digest = 32'hDEADBEEF;
    c_digest_valid = 1'b1;
    @(posedge clk); #1;
    c_digest_valid = 1'b0;
    c_digest = '0;
    #1;
    check("stray_digest", 64'(digest), 64'h956F7883);
    check("stray_digest_valid", 64'(digest_valid), 1);

    run_vec(vt[1], "one_char");
    run_vec(vt[2], "throughput");
    run_vec(vt[3], "backpressure");
    run_vec(vt[4], "long_a");
    prev_b = got_b;
    run_vec(vt[5], "long_b");
    same = (prev_b.size() == got_b.size());
    if (same) foreach (got_b[i]) if (got_b[i] !== prev_b[i]) same = 1'b0;
    check("repeatable", 64'(same), 1);
    run_vec(vt[6], "len255");

    // Reset in the middle of a data beat.
    bp_mode = 1'b0;
    clear_mon();
    s_data  = 32'h0302_0100;
    s_keep  = 3'd4;
    s_last  = 1'b0;
    s_valid = 1'b1;
    ok2 = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #2;
      if (got_b.size() >= 3) begin ok2 = 1'b1; break; end
      s_valid = !s_ready && s_valid && (got_b.size() == 0);
    end
    s_valid = 1'b0;
    check("mid_three_bytes", 64'(ok2), 1);
    check("mid_busy_before", 64'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_c_valid", 64'(c_valid), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_digest_valid", 64'(digest_valid), 0);
    check("mid_rst_s_ready", 64'(s_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vt[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
